// File: rtl/incubator_pkg.sv
// Shared definitions for the incubator loop: the plant model and the
// controller both import this package.
//   temp_t          signed 8-bit degC value seen on the sensor bus
//   Q_W             width of the internal Q8.8 temperature
//   FAN_MAX         fan step above which extra cooling saturates
//   DEF_AMBIENT     default ambient / reset temperature (degC)
//   DEF_TICK_DIV    default clk cycles per thermal update
//   heater_state_e  heater warm-up state machine encoding
//   act_t           registered actuator command bundle
//   sat_q88()       saturate an 18-bit intermediate into Q8.8
package incubator_pkg;

  typedef logic signed [7:0] temp_t;

  localparam int Q_W          = 16;
  localparam int FAN_MAX      = 8;
  localparam int DEF_AMBIENT  = 25;
  localparam int DEF_TICK_DIV = 16;

  typedef enum logic [1:0] {
    H_OFF  = 2'd0,
    H_WARM = 2'd1,
    H_ON   = 2'd2
  } heater_state_e;

  typedef struct packed {
    logic       heater;
    logic       cooler;
    logic [3:0] fan;
  } act_t;

  // Saturate instead of wrapping so a pegged heater cannot roll the
  // temperature over to a large negative value.
  function automatic logic signed [Q_W-1:0] sat_q88(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7fff;
    end else if (v < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[Q_W-1:0];
    end
  endfunction

endpackage

// File: rtl/incubator_plant_model_if.sv
// Controller <-> plant bus.
//   heater, cooler, fan  actuator commands (controller drives)
//   load, load_temp      force the plant temperature (controller/bench drives)
//   sensor               signed degC reading (plant drives)
//   sensor_valid         one-cycle pulse on every sensor update (plant drives)
//   act_conflict         heater and cooler both commanded (plant drives)
// master = controller side, slave = plant side.
interface incubator_plant_model_if;
  import incubator_pkg::*;

  logic       heater;
  logic       cooler;
  logic [3:0] fan;
  logic       load;
  temp_t      load_temp;
  temp_t      sensor;
  logic       sensor_valid;
  logic       act_conflict;

  modport master (
    output heater, cooler, fan, load, load_temp,
    input  sensor, sensor_valid, act_conflict
  );

  modport slave (
    input  heater, cooler, fan, load, load_temp,
    output sensor, sensor_valid, act_conflict
  );
endinterface

// File: rtl/incubator_tick_gen.sv
// Thermal update tick generator. Counts 0..TICK_DIV-1 and wraps; tick is
// high while the count sits on its last value, so the plant updates on that
// clock edge.
//   clk   clock
//   rst   synchronous active-high reset, restarts the count
//   clr   synchronous restart (a load realigns the tick phase)
//   tick  update strobe
module incubator_tick_gen #(
  parameter int TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/incubator_plant_model.sv
// Behavioural thermal plant. Integrates heater, cooler/fan and ambient leak
// into a Q8.8 temperature once per tick and reports its integer part.
//   clk   clock
//   rst   synchronous active-high reset (beats load and tick)
//   bus   plant side of incubator_plant_model_if: actuator commands and
//         load in; sensor, sensor_valid, act_conflict out
module incubator_plant_model
  import incubator_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int AMBIENT    = DEF_AMBIENT,
  parameter int HEAT_RATE  = 64,
  parameter int COOL_RATE  = 64,
  parameter int FAN_GAIN   = 16,
  parameter int HEAT_LAG   = 4,
  parameter int LEAK_EN    = 1,
  parameter int LEAK_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  incubator_plant_model_if.slave  bus
);
  localparam logic signed [Q_W-1:0] AMB_TEMP  = Q_W'(AMBIENT * 256);
  localparam logic signed [17:0]    AMB_Q     = 18'(AMBIENT * 256);
  localparam logic signed [17:0]    HEAT_FULL = 18'(HEAT_RATE);
  localparam logic signed [17:0]    HEAT_HALF = 18'(HEAT_RATE / 2);
  localparam logic signed [17:0]    COOL_BASE = 18'(COOL_RATE);
  localparam logic signed [17:0]    FAN_STEP  = 18'(FAN_GAIN);
  localparam logic [7:0]            LAG_LAST  = 8'(HEAT_LAG - 1);

  act_t                   act_q;
  heater_state_e          h_state, h_next;
  logic [7:0]             lag_cnt, lag_next;
  logic signed [Q_W-1:0]  temp;
  temp_t                  sensor_q;
  logic                   valid_q;

  logic                   tick;
  logic                   tick_adv;
  logic                   conflict;
  logic                   heat_on;
  logic [3:0]             fan_eff;
  logic signed [17:0]     heat_s, cool_s, leak_s, temp_x, sum;
  logic signed [Q_W-1:0]  next_temp;

  incubator_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.load),
    .tick (tick)
  );

  // A load on the tick edge swallows that tick, so the FSM must not advance.
  assign tick_adv = tick & ~bus.load;
  assign conflict = act_q.heater & act_q.cooler;
  assign heat_on  = act_q.heater & ~conflict;

  // Heater warm-up FSM. Dropping the heater or a conflict forces H_OFF on
  // any cycle; the other transitions wait for a tick. The tick that leaves
  // H_OFF already heats at half rate and counts as the first WARM tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    h_next   = h_state;
    lag_next = lag_cnt;
    heat_s   = '0;
    if (!heat_on) begin
      h_next = H_OFF;
    end else begin
      unique case (h_state)
        H_OFF: begin
          heat_s = HEAT_HALF;
          if (tick_adv) begin
            lag_next = 8'd1;
            h_next   = (HEAT_LAG <= 1) ? H_ON : H_WARM;
          end
        end
        H_WARM: begin
          heat_s = HEAT_HALF;
          if (tick_adv) begin
            lag_next = lag_cnt + 8'd1;
            if (lag_cnt >= LAG_LAST) begin
              h_next = H_ON;
            end
          end
        end
        H_ON: begin
          heat_s = HEAT_FULL;
        end
        default: begin
          h_next = H_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_state <= H_OFF;
      lag_cnt <= '0;
    end else begin
      h_state <= h_next;
      lag_cnt <= lag_next;
    end
  end

  // Thermal datapath, 18-bit signed so the sum cannot overflow before the
  // saturation back to Q8.8.
  always_comb begin
    fan_eff = (act_q.fan > 4'(FAN_MAX)) ? 4'(FAN_MAX) : act_q.fan;
    temp_x  = {{2{temp[Q_W-1]}}, temp};
    cool_s  = '0;
    leak_s  = '0;
    if (act_q.cooler && !conflict) begin
      cool_s = COOL_BASE + $signed({14'd0, fan_eff}) * FAN_STEP;
    end
    if (LEAK_EN != 0) begin
      leak_s = (AMB_Q - temp_x) >>> LEAK_SHIFT;
    end
    sum       = temp_x + heat_s - cool_s + leak_s;
    next_temp = sat_q88(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q    <= '0;
      temp     <= AMB_TEMP;
      sensor_q <= temp_t'(AMBIENT);
      valid_q  <= 1'b0;
    end else begin
      act_q   <= '{heater: bus.heater, cooler: bus.cooler, fan: bus.fan};
      valid_q <= 1'b0;
      if (bus.load) begin
        temp     <= {bus.load_temp, 8'd0};
        sensor_q <= bus.load_temp;
        valid_q  <= 1'b1;
      end else if (tick) begin
        temp     <= next_temp;
        sensor_q <= next_temp[Q_W-1:8];
        valid_q  <= 1'b1;
      end
    end
  end

  // act_q is itself a register, so the conflict flag is registered too.
  assign bus.act_conflict = conflict;
  assign bus.sensor       = sensor_q;
  assign bus.sensor_valid = valid_q;
endmodule

// File: tb/tb_incubator_plant_model.sv
// Two plants share one stimulus stream: dut_l with ambient leak, dut_n with
// leak disabled. A reference model predicts every sensor update and pushes
// it into a per-plant queue; a monitor pops and compares on sensor_valid.
module tb_incubator_plant_model;
  import incubator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_heater, in_cooler, in_load;
  int   in_fan, in_load_temp;

  incubator_plant_model_if bus_l ();
  incubator_plant_model_if bus_n ();

  assign bus_l.heater    = in_heater;
  assign bus_l.cooler    = in_cooler;
  assign bus_l.fan       = 4'(in_fan);
  assign bus_l.load      = in_load;
  assign bus_l.load_temp = temp_t'(in_load_temp);
  assign bus_n.heater    = in_heater;
  assign bus_n.cooler    = in_cooler;
  assign bus_n.fan       = 4'(in_fan);
  assign bus_n.load      = in_load;
  assign bus_n.load_temp = temp_t'(in_load_temp);

  incubator_plant_model #(.LEAK_EN(1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  incubator_plant_model #(.LEAK_EN(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  typedef struct {
    int   sensor;
    logic conflict;
  } exp_t;

  exp_t q_l[$];
  exp_t q_n[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  // Temperature in 1/256 degC; heater progress as a count of consecutive
  // heated ticks; ticks as cycles elapsed since the last update or load.
  int   m_temp[2];
  int   m_phase;
  int   m_heat_ticks;
  logic m_h, m_c;
  int   m_fan;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  task automatic model_step();
    logic conflict, heat_on, emit;
    int heat, cool, v, leak;
    emit = 1'b0;
    if (rst) begin
      m_temp[0] = 25 * 256;
      m_temp[1] = 25 * 256;
      m_phase = 0;
      m_heat_ticks = 0;
      m_h = 1'b0;
      m_c = 1'b0;
      m_fan = 0;
      return;
    end
    conflict = m_h & m_c;
    heat_on  = m_h & ~conflict;
    if (!heat_on) m_heat_ticks = 0;
    if (in_load) begin
      m_temp[0] = in_load_temp * 256;
      m_temp[1] = in_load_temp * 256;
      m_phase = 0;
      emit = 1'b1;
    end else if (m_phase == 15) begin
      heat = 0;
      if (heat_on) begin
        heat = (m_heat_ticks < 4) ? 32 : 64;
        m_heat_ticks++;
      end
      cool = (m_c && !conflict) ? 64 + ((m_fan < 8) ? m_fan : 8) * 16 : 0;
      for (int k = 0; k < 2; k++) begin
        leak = (k == 0) ? floor_div(25 * 256 - m_temp[k], 64) : 0;
        v = m_temp[k] + heat - cool + leak;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        m_temp[k] = v;
      end
      m_phase = 0;
      emit = 1'b1;
    end else begin
      m_phase++;
    end
    m_h = in_heater;
    m_c = in_cooler;
    m_fan = in_fan;
    if (emit) begin
      q_l.push_back('{sensor: floor_div(m_temp[0], 256), conflict: m_h & m_c});
      q_n.push_back('{sensor: floor_div(m_temp[1], 256), conflict: m_h & m_c});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (bus_l.sensor_valid === 1'b1) begin
      if (q_l.size() == 0) begin
        total++;
        bad++;
        $display("FAIL leak_valid: got unexpected sensor_valid, expected none");
      end else begin
        e = q_l.pop_front();
        check("leak_sensor", int'(bus_l.sensor), e.sensor);
        check("leak_conflict", int'(bus_l.act_conflict), int'(e.conflict));
      end
    end
    if (bus_n.sensor_valid === 1'b1) begin
      if (q_n.size() == 0) begin
        total++;
        bad++;
        $display("FAIL noleak_valid: got unexpected sensor_valid, expected none");
      end else begin
        e = q_n.pop_front();
        check("noleak_sensor", int'(bus_n.sensor), e.sensor);
        check("noleak_conflict", int'(bus_n.act_conflict), int'(e.conflict));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_step();
    end
  endtask

  task automatic set_act(input logic h, input logic c, input int f);
    in_heater = h;
    in_cooler = c;
    in_fan    = f;
  endtask

  task automatic do_load(input int t);
    in_load      = 1'b1;
    in_load_temp = t;
    step(1);
    in_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_load = 1'b0;
    in_load_temp = 0;
    set_act(1'b0, 1'b0, 0);
    step(3);
    check("rst_sensor_l", int'(bus_l.sensor), 25);
    check("rst_sensor_n", int'(bus_n.sensor), 25);
    check("rst_valid", int'(bus_l.sensor_valid), 0);
    check("rst_conflict", int'(bus_n.act_conflict), 0);
    rst = 1'b0;

    // idle at ambient: steady 25 with an update every 16 clocks
    step(5 * 16);
    check("idle_sensor", int'(bus_l.sensor), 25);

    // heater ramp from 10: four half-rate ticks then full rate
    set_act(1'b1, 1'b0, 0);
    do_load(10);
    step(6 * 16);
    check("heat_ramp_6th", int'(bus_n.sensor), 11);

    // cooler at fan 8, then fan 15 clamps to the same result
    set_act(1'b0, 1'b1, 8);
    do_load(40);
    step(4 * 16);
    check("cool_fan8", int'(bus_n.sensor), 37);
    set_act(1'b0, 1'b1, 15);
    do_load(40);
    step(4 * 16);
    check("cool_fan15", int'(bus_n.sensor), 37);

    // saturation at both ends
    set_act(1'b1, 1'b0, 0);
    do_load(127);
    step(8 * 16);
    check("sat_high", int'(bus_n.sensor), 127);
    set_act(1'b0, 1'b1, 0);
    do_load(-128);
    step(8 * 16);
    check("sat_low", int'(bus_n.sensor), -128);

    // conflicting actuators
    set_act(1'b1, 1'b1, 5);
    step(1);
    check("conflict_flag", int'(bus_n.act_conflict), 1);
    step(2 * 16);
    check("conflict_hold", int'(bus_n.sensor), -128);

    // load exactly on a tick edge: the tick is dropped, phase restarts
    set_act(1'b0, 1'b0, 0);
    for (int i = 0; i < 32 && m_phase != 15; i++) step(1);
    do_load(50);
    check("load_on_tick", int'(bus_n.sensor), 50);
    check("load_on_tick_valid", int'(bus_n.sensor_valid), 1);
    step(15);
    check("tick_restart_quiet", int'(bus_n.sensor_valid), 0);
    step(1);
    check("tick_restart_fire", int'(bus_n.sensor_valid), 1);

    // reset while the heater is warming
    set_act(1'b1, 1'b0, 0);
    do_load(20);
    step(2 * 16 + 5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midwarm_rst_sensor", int'(bus_n.sensor), 25);
    check("midwarm_rst_valid", int'(bus_n.sensor_valid), 0);
    check("midwarm_rst_conflict", int'(bus_l.act_conflict), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 999) == 0);
      in_load      = ($urandom_range(0, 79) == 0);
      in_load_temp = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 127) == 0) in_heater = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0)  in_cooler = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)   in_fan = int'($urandom_range(0, 15));
      step(1);
    end
    rst = 1'b0;
    in_load = 1'b0;
    set_act(1'b0, 1'b0, 0);
    step(2);
    @(negedge clk);
    #1;
    check("pending_l", q_l.size(), 0);
    check("pending_n", q_n.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
